mcu_sequencer: RTL and testbench
================================

Name: mcu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 17-bit single-bus processor.
- Owns the program counter (PC) and the instruction register (IR). The IR feeds the instruction decoder.
- Gates the decoder's register-write (RW) and memory-write (MW) strobes into single-cycle enables.
- Handshakes with instruction memory and data memory, and retires one instruction at a time.

Parameters:
- PC_W, 8, width of PC and of memory addresses.
- OFS_W, 6, width of the signed branch offset from the datapath.
- HALT_OPC, 7'h7F, IR[16:10] value that halts the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching at PC.
- imem_req  out  1  instruction fetch request; address is pc.
- imem_ack  in  1  instruction data valid this cycle.
- instr_rdata  in  17  fetched instruction.
- ir  out  17  instruction register, drives the decoder's Instruction_in.
- pc  out  PC_W  program counter.
- BS  in  2  branch select from the decoder.
- PS  in  1  branch polarity from the decoder.
- MW  in  1  memory write from the decoder.
- RW  in  1  register write from the decoder.
- MD  in  2  destination mux select; MD==2'b01 means memory read.
- Z, N  in  1 each  zero and negative flags from the function unit, valid in EXEC.
- br_offset  in  OFS_W  signed PC-relative offset.
- jmp_addr  in  PC_W  absolute jump target (from Bus A).
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  data memory write enable; equals MW while dmem_req is high.
- dmem_ack  in  1  data access complete.
- rw_en  out  1  register file write strobe.
- halted  out  1  sticky halt indicator.
- retired  out  16  count of retired instructions; wraps.

Behaviour:
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (any state): state=IDLE, pc=0, ir=0, retired=0. All strobes low: imem_req, dmem_req, dmem_we, rw_en, halted. Outstanding requests are dropped and no ack is honoured afterwards.
- IDLE: outputs quiet. On start=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 while in FETCH.
  - On imem_ack: ir<=instr_rdata, go to DECODE.
  - Without ack: stay in FETCH with the request held.
- DECODE: one cycle for decoder outputs to settle. If ir[16:10]==HALT_OPC, go to HALT; otherwise go to EXEC.
- EXEC:
  - Latch the branch decision from BS, PS, Z, N.
  - If MW=1 or MD==2'b01, go to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1 and dmem_we=MW, held until dmem_ack.
  - dmem_ack in the first MEM cycle is allowed; the next state is then WB.
- WB:
  - rw_en=RW for exactly this one cycle.
  - pc is updated, retired increments, and the next state is FETCH.
- PC update in WB; arithmetic is modulo 2^PC_W:
  - BS=00: pc+1.
  - BS=01: pc+sext(br_offset) if Z==PS, else pc+1.
  - BS=10: jmp_addr.
  - BS=11: pc+sext(br_offset) if N==PS, else pc+1.
- The branch decision uses flags sampled in EXEC, not in WB.
- Latency with zero-wait acks:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5 cycles.
- HALT: halted=1, all strobes low, pc frozen. The HALT instruction is not counted in retired. Only rst exits HALT; start is ignored.
- start while not in IDLE is ignored.
- Acks arriving outside their request state are ignored.
- retired wraps from 16'hFFFF to 0.
- At most one request (imem_req or dmem_req) is high in any cycle.

Decomposition:
- Shared package (mcu_pkg):
  - FSM state encoding.
  - BS codes: BS_INC, BS_BZ, BS_JMP, BS_BN.
  - MD_MEM = 2'b01.
  - Default HALT_OPC.
- One sub-module, mcu_pc_next: combinational next-PC unit (BS/PS/flag decode, sign extension, adder). The FSM, IR, counter and handshakes stay in the top module.

Test Plan:
- Reset then start, instr_rdata=ADD encoding with RW=1, BS=00, all acks zero-wait -> imem_req in cycle 1, rw_en pulses once in cycle 4, pc 0->1, retired=1.
- Store (MW=1), dmem_ack delayed 3 cycles -> dmem_req and dmem_we held 3 cycles, rw_en never asserted, pc=1 after WB.
- BS=01, PS=1, Z=1, br_offset=-2, pc=5 -> pc=3. Repeat with Z=0 -> pc=6.
- BS=10, jmp_addr=8'hA0 -> pc=8'hA0. With pc=8'hFF, BS=00 -> pc wraps to 0.
- imem_ack withheld 4 cycles, then rst asserted mid-FETCH -> next cycle IDLE, imem_req=0, pc=0; a late imem_ack does not load ir.
- Fetch of instruction with ir[16:10]=7'h7F -> halted=1 after DECODE, retired unchanged; start ignored; rst clears halted.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the 17-bit single-bus processor sequencer.
package mcu_pkg;

  // Sequencer states; the explicit values keep the legacy 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Branch-select codes produced by the instruction decoder.
  localparam logic [1:0] BS_INC = 2'b00;
  localparam logic [1:0] BS_BZ  = 2'b01;
  localparam logic [1:0] BS_JMP = 2'b10;
  localparam logic [1:0] BS_BN  = 2'b11;

  // Destination-mux select value that denotes a data-memory read.
  localparam logic [1:0] MD_MEM = 2'b01;

  // Opcode field value (IR[16:10]) that stops the sequencer.
  localparam logic [6:0] HALT_OPC_DEF = 7'h7F;

  // An instruction needs the MEM phase when it writes memory or loads from it.
  function automatic logic needs_mem(input logic mw, input logic [1:0] md);
    return mw | (md == MD_MEM);
  endfunction

endpackage

// File: rtl/mcu_pc_next.sv
// Combinational next-PC unit: branch condition decode, offset sign
// extension and the PC adder. Arithmetic wraps modulo 2^PC_W.
module mcu_pc_next
  import mcu_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OFS_W = 6
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [1:0]       bs,
  input  logic             ps,
  input  logic             z,
  input  logic             n,
  input  logic [OFS_W-1:0] br_offset,
  input  logic [PC_W-1:0]  jmp_addr,
  input  logic             taken,
  output logic             take_now,
  output logic [PC_W-1:0]  pc_next
);

  logic [PC_W-1:0] ofs_ext;

  assign ofs_ext = {{(PC_W-OFS_W){br_offset[OFS_W-1]}}, br_offset};

  // Branch condition from the live flags; the caller latches it in EXEC.
  always_comb begin
    take_now = 1'b0;
    unique case (bs)
      BS_BZ:   take_now = (z == ps);
      BS_BN:   take_now = (n == ps);
      default: take_now = 1'b0;
    endcase
  end

  // Target selection using the latched decision rather than the live flags.
  always_comb begin
    pc_next = pc + PC_W'(1);
    unique case (bs)
      BS_JMP:       pc_next = jmp_addr;
      BS_BZ, BS_BN: pc_next = taken ? (pc + ofs_ext) : (pc + PC_W'(1));
      default:      pc_next = pc + PC_W'(1);
    endcase
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Fetch/decode/execute controller: owns PC and IR, gates decoder write
// strobes into single-cycle enables and handshakes with both memories.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned OFS_W    = 6,
  parameter logic [6:0]  HALT_OPC = HALT_OPC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [16:0]      instr_rdata,
  output logic [16:0]      ir,
  output logic [PC_W-1:0]  pc,
  input  logic [1:0]       BS,
  input  logic             PS,
  input  logic             MW,
  input  logic             RW,
  input  logic [1:0]       MD,
  input  logic             Z,
  input  logic             N,
  input  logic [OFS_W-1:0] br_offset,
  input  logic [PC_W-1:0]  jmp_addr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rw_en,
  output logic             halted,
  output logic [15:0]      retired
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [16:0]     ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic            taken_q, taken_d;
  logic            take_now;
  logic [PC_W-1:0] pc_next;

  mcu_pc_next #(
    .PC_W  (PC_W),
    .OFS_W (OFS_W)
  ) u_pc_next (
    .pc        (pc_q),
    .bs        (BS),
    .ps        (PS),
    .z         (Z),
    .n         (N),
    .br_offset (br_offset),
    .jmp_addr  (jmp_addr),
    .taken     (taken_q),
    .take_now  (take_now),
    .pc_next   (pc_next)
  );

  // State transitions plus the PC/IR/retire-counter updates they trigger.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    taken_d   = taken_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (ir_q[16:10] == HALT_OPC) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        // Flags are only valid here, so the branch decision is frozen now.
        taken_d = take_now;
        state_d = needs_mem(MW, MD) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        pc_d      = pc_next;
        retired_d = retired_q + 16'd1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  // Strobes are pure state decodes, so only one request can ever be high.
  always_comb begin
    imem_req = (state_q == ST_FETCH);
    dmem_req = (state_q == ST_MEM);
    dmem_we  = (state_q == ST_MEM) & MW;
    rw_en    = (state_q == ST_WB) & RW;
    halted   = (state_q == ST_HALT);
  end

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: directed scenarios followed by
// randomized instructions checked against a transaction-level model.
module tb_mcu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, dmem_ack;
  logic [16:0] instr_rdata;
  logic [1:0]  BS, MD;
  logic        PS, MW, RW, Z, N;
  logic [5:0]  br_offset;
  logic [7:0]  jmp_addr;
  logic        imem_req, dmem_req, dmem_we, rw_en, halted;
  logic [16:0] ir;
  logic [7:0]  pc;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pc   = 0;
  int exp_ret  = 0;

  always #5 clk = ~clk;

  mcu_sequencer #(
    .PC_W     (8),
    .OFS_W    (6),
    .HALT_OPC (7'h7F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .instr_rdata (instr_rdata),
    .ir          (ir),
    .pc          (pc),
    .BS          (BS),
    .PS          (PS),
    .MW          (MW),
    .RW          (RW),
    .MD          (MD),
    .Z           (Z),
    .N           (N),
    .br_offset   (br_offset),
    .jmp_addr    (jmp_addr),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ack    (dmem_ack),
    .rw_en       (rw_en),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural PC rule, computed with plain integer arithmetic.
  function automatic int model_pc(input int cur, input logic [1:0] bs, input logic ps,
                                  input logic z, input logic n, input logic [5:0] ofs,
                                  input logic [7:0] jmp);
    int o;
    int r;
    o = (int'(ofs) >= 32) ? int'(ofs) - 64 : int'(ofs);
    case (bs)
      2'd0:    r = cur + 1;
      2'd1:    r = (z == ps) ? cur + o : cur + 1;
      2'd2:    r = int'(jmp);
      default: r = (n == ps) ? cur + o : cur + 1;
    endcase
    return (r + 256) % 256;
  endfunction

  // Called at a falling edge while the DUT is in FETCH; returns at the
  // falling edge of the following FETCH cycle.
  task automatic run_instr(input logic [16:0] instr, input logic [1:0] bs, input logic ps,
                           input logic mw, input logic rw, input logic [1:0] md,
                           input logic z, input logic n, input logic [5:0] ofs,
                           input logic [7:0] jmp, input int fetch_wait, input int mem_cycles,
                           input bit noise);
    bit is_mem;
    is_mem = mw || (md == 2'b01);
    BS = bs; PS = ps; MW = mw; RW = rw; MD = md;
    for (int d = 0; d <= fetch_wait; d++) begin
      if (d > 0) @(negedge clk);
      check("fetch_imem_req", 32'(imem_req), 1);
      check("fetch_dmem_req", 32'(dmem_req), 0);
      check("fetch_pc", 32'(pc), exp_pc);
      imem_ack    = (d == fetch_wait);
      instr_rdata = (d == fetch_wait) ? instr : 17'($urandom);
      dmem_ack    = noise ? 1'($urandom) : 1'b0;
      start       = noise ? 1'($urandom) : 1'b0;
      Z = 1'($urandom); N = 1'($urandom);
    end
    @(negedge clk);  // DECODE
    check("decode_ir", 32'(ir), 32'(instr));
    check("decode_imem_req", 32'(imem_req), 0);
    check("decode_rw_en", 32'(rw_en), 0);
    imem_ack    = noise ? 1'($urandom) : 1'b0;
    instr_rdata = 17'($urandom);
    Z = z; N = n; br_offset = ofs; jmp_addr = jmp;
    @(negedge clk);  // EXEC
    check("exec_strobes", 32'({imem_req, dmem_req, dmem_we, rw_en, halted}), 0);
    dmem_ack = noise ? 1'($urandom) : 1'b0;
    if (is_mem) begin
      for (int d = 1; d <= mem_cycles; d++) begin
        @(negedge clk);  // MEM
        check("mem_dmem_req", 32'(dmem_req), 1);
        check("mem_dmem_we", 32'(dmem_we), 32'(mw));
        check("mem_other", 32'({imem_req, rw_en}), 0);
        dmem_ack = (d == mem_cycles);
        Z = ~z; N = ~n;
        imem_ack = noise ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge clk);  // WB
    check("wb_rw_en", 32'(rw_en), 32'(rw));
    check("wb_requests", 32'({imem_req, dmem_req, dmem_we}), 0);
    check("wb_ir_held", 32'(ir), 32'(instr));
    Z = ~z; N = ~n;
    dmem_ack = noise ? 1'($urandom) : 1'b0;
    imem_ack = noise ? 1'($urandom) : 1'b0;
    exp_pc  = model_pc(exp_pc, bs, ps, z, n, ofs, jmp);
    exp_ret = (exp_ret + 1) % 65536;
    @(negedge clk);  // next FETCH
    check("retire_pc", 32'(pc), exp_pc);
    check("retire_count", 32'(retired), exp_ret);
    imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [6:0] opc;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    instr_rdata = '0; BS = '0; MD = '0; PS = 1'b0; MW = 1'b0; RW = 1'b0;
    Z = 1'b0; N = 1'b0; br_offset = '0; jmp_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_pc", 32'(pc), 0);
    check("reset_ir", 32'(ir), 0);
    check("reset_retired", 32'(retired), 0);
    check("reset_strobes", 32'({imem_req, dmem_req, dmem_we, rw_en, halted}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", 32'({imem_req, dmem_req, rw_en}), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // ADD, zero-wait: FETCH, DECODE, EXEC, WB.
    run_instr({7'h02, 10'h0C5}, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6'd0, 8'h00, 0, 1, 1'b0);
    // Store with a three-cycle data handshake.
    run_instr({7'h05, 10'h012}, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 8'h00, 0, 3, 1'b0);
    // Load path via MD.
    run_instr({7'h06, 10'h034}, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 6'd0, 8'h00, 1, 1, 1'b0);
    // Branch on zero, taken and not taken, from pc=5.
    run_instr({7'h10, 10'h000}, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 8'h05, 0, 1, 1'b0);
    run_instr({7'h11, 10'h000}, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 6'h3E, 8'h00, 0, 1, 1'b0);
    check("bz_taken_pc", 32'(pc), 3);
    run_instr({7'h10, 10'h000}, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 8'h05, 0, 1, 1'b0);
    run_instr({7'h11, 10'h000}, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'h3E, 8'h00, 0, 1, 1'b0);
    check("bz_not_taken_pc", 32'(pc), 6);
    // Jump, then increment wrap at the top of the address space.
    run_instr({7'h10, 10'h000}, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 8'hA0, 0, 1, 1'b0);
    check("jmp_pc", 32'(pc), 32'h0A0);
    run_instr({7'h10, 10'h000}, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 8'hFF, 0, 1, 1'b0);
    run_instr({7'h02, 10'h000}, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6'd0, 8'h00, 0, 1, 1'b0);
    check("pc_wrap", 32'(pc), 0);
    // Branch on negative with N mismatching polarity.
    run_instr({7'h12, 10'h000}, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 6'h05, 8'h00, 0, 1, 1'b0);

    // Randomized instructions with stray acks and start pulses.
    for (int i = 0; i < 150; i++) begin
      opc = 7'($urandom_range(0, 126));
      run_instr({opc, 10'($urandom)}, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b1);
    end

    // Reset while a fetch is stalled; a late ack must not load IR.
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_imem_req", 32'(imem_req), 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_fetch_imem_req", 32'(imem_req), 0);
    check("rst_fetch_pc", 32'(pc), 0);
    check("rst_fetch_retired", 32'(retired), 0);
    rst = 1'b0; imem_ack = 1'b1; instr_rdata = 17'h1ABCD;
    @(negedge clk);
    check("late_ack_ir", 32'(ir), 0);
    check("late_ack_idle", 32'(imem_req), 0);
    imem_ack = 1'b0;
    exp_pc = 0; exp_ret = 0;

    // One retired instruction, then HALT.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_instr({7'h03, 10'h001}, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6'd0, 8'h00, 0, 1, 1'b0);
    check("pre_halt_imem_req", 32'(imem_req), 1);
    imem_ack = 1'b1; instr_rdata = {7'h7F, 10'h155};
    @(negedge clk);  // DECODE
    imem_ack = 1'b0;
    check("halt_decode_halted", 32'(halted), 0);
    @(negedge clk);
    check("halted_set", 32'(halted), 1);
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("halt_sticky", 32'(halted), 1);
    check("halt_strobes", 32'({imem_req, dmem_req, dmem_we, rw_en}), 0);
    check("halt_pc", 32'(pc), exp_pc);
    check("halt_retired", 32'(retired), exp_ret);
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_clears_halted", 32'(halted), 0);
    check("rst_clears_pc", 32'(pc), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
